rx_queue_select: RTL and testbench
==================================

# rx_queue_select

RSS queue-selection stage directly downstream of the RX hash generator. Takes the per-frame Toeplitz hash pulse (`crx_hash` / `crx_hash_valid`) and looks it up in a software-programmed 2^TBL_AW-entry indirection table. It queues the result in a small FIFO and presents `{queue index, hash}` to the rx_engine over a valid/ready handshake. The hash source cannot be back-pressured, so overflow drops the entry and counts it.

## Interface
- QIDX_WIDTH, 8, width of a receive queue index
- TBL_AW, 7, indirection-table address width (128 entries)
- FIFO_AW, 2, log2 of result FIFO depth (4 entries)
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- crx_hash_valid  in  1  single-cycle hash pulse, one per frame, no backpressure
- crx_hash  in  `HASH_WIDTH  frame hash, qualified by crx_hash_valid
- cfg_rss_en  in  1  1: table lookup; 0: steer to cfg_default_queue
- cfg_default_queue  in  QIDX_WIDTH  queue used when RSS disabled
- cfg_tbl_wr_en  in  1  indirection-table write strobe
- cfg_tbl_wr_addr  in  TBL_AW  table write address
- cfg_tbl_wr_data  in  QIDX_WIDTH  table write data
- qsel_valid  out  1  result available at FIFO head
- qsel_ready  in  1  rx_engine accepts head entry
- qsel_queue  out  QIDX_WIDTH  selected queue
- qsel_hash  out  `HASH_WIDTH  hash carried with result
- qsel_drop_cnt  out  32  entries dropped on FIFO overflow

## Operation
- Stage S1 (register stage) is loaded on crx_hash_valid.
  - s1_hash <= crx_hash.
  - s1_queue <= cfg_rss_en ? table[crx_hash[TBL_AW-1:0]] : cfg_default_queue.
  - s1_valid <= crx_hash_valid.
- Table: flop array; every entry resets to 0.
- Table write: if cfg_tbl_wr_en, table[cfg_tbl_wr_addr] <= cfg_tbl_wr_data.
- Write and lookup of the same address in the same cycle: the lookup returns the old value; the write takes effect from the next cycle.
- Hash value 0, including non-IPv4 frames, is looked up normally (entry 0).
- FIFO is show-ahead with 2^FIFO_AW entries of {s1_queue, s1_hash}.
  - push = s1_valid.
  - pop = qsel_valid & qsel_ready.
- Full handling:
  - push & full & !pop: the entry is discarded and qsel_drop_cnt increments, saturating at 0xFFFF_FFFF.
  - push & full & pop: the push is accepted and the count does not change.
- Empty: qsel_valid=0. qsel_queue and qsel_hash are don't-care but remain stable (they show the last head contents).
- Once asserted, qsel_valid and its data stay stable until accepted.
- Pointer counters are FIFO_AW+1 bits and wrap naturally. full is MSB-differ / rest-equal; empty is pointers equal.

## Timing
- Reset values:
  - outputs: qsel_valid=0, qsel_queue=0, qsel_hash=0, qsel_drop_cnt=0.
  - internal: s1_valid=0, FIFO pointers 0, table all 0.
- Latency: crx_hash_valid in cycle N gives qsel_valid=1 in cycle N+2 when the FIFO was empty.
- Throughput: one hash per cycle accepted into S1; one result per cycle popped.
- Mid-operation reset: all state clears asynchronously, including the table, so software must reprogram it. Hash pulses during reset are lost.
- Config inputs are sampled only in the S1 load cycle; changing them does not alter entries already in S1 or the FIFO.

## Configuration
- RX_QSEL_DROP_CNT_EN
  - Defined: 32-bit saturating drop counter implemented as above.
  - Undefined: counter logic is removed and qsel_drop_cnt is tied to 0. Overflow entries are still discarded silently.

## Test plan
- Reset, then write table[0x05]=0x3, cfg_rss_en=1, crx_hash=0x1234_5685 -> two cycles later qsel_valid=1, qsel_queue=0x3, qsel_hash=0x1234_5685.
- cfg_rss_en=0, cfg_default_queue=0x7, crx_hash=0xFFFF_FFFF -> qsel_queue=0x7, regardless of table[0x7F].
- Same cycle: cfg_tbl_wr (addr 0x10, data 0x9) and crx_hash=0x10 with table[0x10]=0x2 -> qsel_queue=0x2. The next hash 0x10 yields 0x9.
- qsel_ready=0, six back-to-back hashes -> first four are held in order, qsel_drop_cnt=2. Then qsel_ready=1 -> four results drain in order, then qsel_valid=0.
- FIFO full, push and pop in the same cycle -> no drop, FIFO remains full, order preserved.
- Assert rst_n=0 with three entries queued -> qsel_valid=0 immediately; after release the table reads 0 and qsel_drop_cnt=0.

Source files
------------

// File: rtl/rx_queue_select_if.sv
// ---------------------------------------------------------------------------
// rx_queue_select_if
//   Result handshake between rx_queue_select and the rx_engine.
//   master (rx_queue_select): drives valid, queue, hash; samples ready.
//   slave  (rx_engine)      : samples valid, queue, hash; drives ready.
//   Signals:
//     valid  - result present at FIFO head
//     ready  - consumer accepts the head entry this cycle
//     queue  - selected receive queue index (QIDX_WIDTH bits)
//     hash   - frame hash carried alongside the result (HASH_WIDTH bits)
// ---------------------------------------------------------------------------
`ifndef HASH_WIDTH
`define HASH_WIDTH 32
`endif

interface rx_queue_select_if #(
    parameter int QIDX_WIDTH = 8,
    parameter int HASH_WIDTH = `HASH_WIDTH
);
    logic                  valid;
    logic                  ready;
    logic [QIDX_WIDTH-1:0] queue;
    logic [HASH_WIDTH-1:0] hash;

    modport master (output valid, output queue, output hash, input ready);
    modport slave  (input valid, input queue, input hash, output ready);
endinterface

// File: rtl/rx_queue_select.sv
// ---------------------------------------------------------------------------
// rx_queue_select
//   RSS queue selection. Each crx_hash_valid pulse is registered in S1
//   together with its queue index, taken either from a 2^TBL_AW-entry
//   indirection table (cfg_rss_en=1) or from cfg_default_queue. S1 feeds
//   a show-ahead FIFO of 2^FIFO_AW {queue, hash} entries that is drained
//   over the qsel valid/ready handshake. The hash source cannot stall, so
//   a push into a full FIFO that is not popped in the same cycle is
//   discarded.
//
//   Ports:
//     clk, rst_n          - clock; asynchronous active-low reset
//     crx_hash_valid/hash - single-cycle frame hash pulse
//     cfg_rss_en          - 1: table lookup, 0: cfg_default_queue
//     cfg_default_queue   - queue used when RSS is disabled
//     cfg_tbl_wr_*        - indirection-table write port
//     qsel                - result handshake (rx_queue_select_if.master)
//     qsel_drop_cnt       - saturating count of overflow drops
//
//   Build option:
//     RX_QSEL_DROP_CNT_EN - when defined, qsel_drop_cnt is a 32-bit
//                           saturating counter; otherwise it is tied to 0
//                           and overflow entries are dropped silently.
//   HASH_WIDTH (macro) sets the hash width, default 32.
// ---------------------------------------------------------------------------
`ifndef HASH_WIDTH
`define HASH_WIDTH 32
`endif

module rx_queue_select #(
    parameter int QIDX_WIDTH = 8,
    parameter int TBL_AW     = 7,
    parameter int FIFO_AW    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   crx_hash_valid,
    input  logic [`HASH_WIDTH-1:0] crx_hash,
    input  logic                   cfg_rss_en,
    input  logic [QIDX_WIDTH-1:0]  cfg_default_queue,
    input  logic                   cfg_tbl_wr_en,
    input  logic [TBL_AW-1:0]      cfg_tbl_wr_addr,
    input  logic [QIDX_WIDTH-1:0]  cfg_tbl_wr_data,
    rx_queue_select_if.master      qsel,
    output logic [31:0]            qsel_drop_cnt
);

    localparam int HASH_W     = `HASH_WIDTH;
    localparam int TBL_SIZE   = 1 << TBL_AW;
    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam int ENTRY_W    = QIDX_WIDTH + HASH_W;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    // -----------------------------------------------------------------------
    // Indirection table (flop array so the whole table clears on reset)
    // -----------------------------------------------------------------------
    logic [QIDX_WIDTH-1:0] tbl_reg [TBL_SIZE];
    logic [TBL_SIZE-1:0]   tbl_we;

    genvar gi;
    generate
        for (gi = 0; gi < TBL_SIZE; gi++) begin : g_tbl_we
            assign tbl_we[gi] = cfg_tbl_wr_en && (cfg_tbl_wr_addr == TBL_AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_SIZE; i++) begin
                tbl_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TBL_SIZE; i++) begin
                if (tbl_we[i]) begin
                    tbl_reg[i] <= cfg_tbl_wr_data;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // S1: lookup is taken from the table contents before any same-cycle
    // write lands, so a simultaneous write/lookup returns the old entry.
    // -----------------------------------------------------------------------
    logic                  s1_valid_reg;
    logic [HASH_W-1:0]     s1_hash_reg;
    logic [QIDX_WIDTH-1:0] s1_queue_reg;
    logic [QIDX_WIDTH-1:0] lookup_queue;

    assign lookup_queue = cfg_rss_en ? tbl_reg[crx_hash[TBL_AW-1:0]] : cfg_default_queue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_hash_reg  <= '0;
            s1_queue_reg <= '0;
        end else begin
            s1_valid_reg <= crx_hash_valid;
            if (crx_hash_valid) begin
                s1_hash_reg  <= crx_hash;
                s1_queue_reg <= lookup_queue;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Result FIFO (show-ahead). Pointers carry one extra wrap bit.
    // -----------------------------------------------------------------------
    logic [FIFO_AW:0]     wr_ptr_reg;
    logic [FIFO_AW:0]     rd_ptr_reg;
    logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   head_entry;
    logic [ENTRY_W-1:0]   hold_reg;
    logic [ENTRY_W-1:0]   out_entry;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 push_ok;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                        (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
    assign pop        = !fifo_empty && qsel.ready;
    // When full, a same-cycle pop frees the slot the push is about to use.
    assign push_ok    = s1_valid_reg && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg[FIFO_AW-1:0]] <= {s1_queue_reg, s1_hash_reg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            hold_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                hold_reg   <= head_entry;
            end
        end
    end

    assign head_entry = fifo_mem[rd_ptr_reg[FIFO_AW-1:0]];
    // While empty, show the last popped head so the data lines stay still.
    assign out_entry  = fifo_empty ? hold_reg : head_entry;

    assign qsel.valid = !fifo_empty;
    assign qsel.queue = out_entry[ENTRY_W-1 -: QIDX_WIDTH];
    assign qsel.hash  = out_entry[HASH_W-1:0];

    // -----------------------------------------------------------------------
    // Overflow drop counter
    // -----------------------------------------------------------------------
`ifdef RX_QSEL_DROP_CNT_EN
    logic        drop;
    logic [31:0] drop_cnt_reg;

    assign drop = s1_valid_reg && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != 32'hFFFF_FFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 32'd1;
        end
    end

    assign qsel_drop_cnt = drop_cnt_reg;
`else
    assign qsel_drop_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rx_queue_select.sv
module tb_rx_queue_select;

    localparam int QW    = 8;
    localparam int HW    = 32;
    localparam int TAW   = 7;
    localparam int DEPTH = 4;
`ifdef RX_QSEL_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          crx_hash_valid = 1'b0;
    logic [HW-1:0] crx_hash = '0;
    logic          cfg_rss_en = 1'b0;
    logic [QW-1:0] cfg_default_queue = '0;
    logic          cfg_tbl_wr_en = 1'b0;
    logic [TAW-1:0] cfg_tbl_wr_addr = '0;
    logic [QW-1:0] cfg_tbl_wr_data = '0;
    logic [31:0]   qsel_drop_cnt;

    rx_queue_select_if #(.QIDX_WIDTH(QW), .HASH_WIDTH(HW)) qif ();

    rx_queue_select #(.QIDX_WIDTH(QW), .TBL_AW(TAW), .FIFO_AW(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .crx_hash_valid    (crx_hash_valid),
        .crx_hash          (crx_hash),
        .cfg_rss_en        (cfg_rss_en),
        .cfg_default_queue (cfg_default_queue),
        .cfg_tbl_wr_en     (cfg_tbl_wr_en),
        .cfg_tbl_wr_addr   (cfg_tbl_wr_addr),
        .cfg_tbl_wr_data   (cfg_tbl_wr_data),
        .qsel              (qif),
        .qsel_drop_cnt     (qsel_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Occupancy + ordered list of accepted results; frames travel one cycle
    // in a staging slot before they compete for FIFO space.
    logic [QW-1:0]    m_tbl [1 << TAW];
    logic [QW+HW-1:0] exp_q [$];
    int               m_cnt;
    bit               m_s1_v;
    logic [QW+HW-1:0] m_s1;
    logic [31:0]      m_drops;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   = 0;
            m_s1_v  = 1'b0;
            m_s1    = '0;
            m_drops = '0;
            exp_q.delete();
            foreach (m_tbl[i]) m_tbl[i] = '0;
        end else begin
            bit m_pop;
            m_pop = (m_cnt > 0) && qif.ready;
            if (m_s1_v) begin
                if (m_cnt < DEPTH || m_pop) begin
                    exp_q.push_back(m_s1);
                    m_cnt++;
                end else if (m_drops != 32'hFFFF_FFFF) begin
                    m_drops++;
                end
            end
            if (m_pop) m_cnt--;
            m_s1_v = crx_hash_valid;
            if (crx_hash_valid)
                m_s1 = {(cfg_rss_en ? m_tbl[crx_hash[TAW-1:0]] : cfg_default_queue), crx_hash};
            if (cfg_tbl_wr_en) m_tbl[cfg_tbl_wr_addr] = cfg_tbl_wr_data;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            logic [QW+HW-1:0] e;
            chk("valid", 64'(qif.valid), 64'(m_cnt > 0));
            chk("drop_cnt", 64'(qsel_drop_cnt), 64'(DROP_EN ? m_drops : 32'd0));
            if (qif.valid && qif.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=q%0h/h%0h required=none @%0t",
                             qif.queue, qif.hash, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_queue", 64'(qif.queue), 64'(e[QW+HW-1:HW]));
                    chk("out_hash", 64'(qif.hash), 64'(e[HW-1:0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_hash(input logic [HW-1:0] h);
        crx_hash_valid = 1'b1;
        crx_hash = h;
        tick();
        crx_hash_valid = 1'b0;
    endtask

    task automatic tbl_write(input logic [TAW-1:0] a, input logic [QW-1:0] d);
        cfg_tbl_wr_en = 1'b1;
        cfg_tbl_wr_addr = a;
        cfg_tbl_wr_data = d;
        tick();
        cfg_tbl_wr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        qif.ready = 1'b1;
        for (int i = 0; i < 20 && (qif.valid || m_s1_v); i++) tick();
        tick();
        chk({name, "_empty"}, 64'(qif.valid), 64'd0);
        chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] d0;
        qif.ready = 1'b1;
        #1;
        chk("rst_valid", 64'(qif.valid), 64'd0);
        chk("rst_queue", 64'(qif.queue), 64'd0);
        chk("rst_hash", 64'(qif.hash), 64'd0);
        chk("rst_drop", 64'(qsel_drop_cnt), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // basic lookup with latency of two cycles
        tbl_write(7'h05, 8'h03);
        cfg_rss_en = 1'b1;
        send_hash(32'h1234_5685);
        chk("lat_not_early", 64'(qif.valid), 64'd0);
        tick();
        chk("t1_valid", 64'(qif.valid), 64'd1);
        chk("t1_queue", 64'(qif.queue), 64'h03);
        chk("t1_hash", 64'(qif.hash), 64'h1234_5685);
        tick();

        // RSS disabled steers to default queue
        tbl_write(7'h7F, 8'h55);
        cfg_rss_en = 1'b0;
        cfg_default_queue = 8'h07;
        send_hash(32'hFFFF_FFFF);
        tick();
        chk("t2_queue", 64'(qif.queue), 64'h07);
        tick();

        // same-cycle write and lookup returns old entry
        cfg_rss_en = 1'b1;
        tbl_write(7'h10, 8'h02);
        cfg_tbl_wr_en = 1'b1;
        cfg_tbl_wr_addr = 7'h10;
        cfg_tbl_wr_data = 8'h09;
        send_hash(32'h10);
        cfg_tbl_wr_en = 1'b0;
        send_hash(32'h10);
        chk("t3_old", 64'(qif.queue), 64'h02);
        tick();
        chk("t3_new", 64'(qif.queue), 64'h09);
        drain("t3");

        // overflow: six back-to-back with no consumer
        qif.ready = 1'b0;
        d0 = qsel_drop_cnt;
        for (int i = 0; i < 6; i++) send_hash(32'hA000_0000 + 32'(i));
        tick(); tick();
        chk("t4_head", 64'(qif.hash), 64'hA000_0000);
        chk("t4_drops", 64'(qsel_drop_cnt - d0), 64'(DROP_EN ? 32'd2 : 32'd0));
        drain("t4");

        // full FIFO with simultaneous push and pop
        qif.ready = 1'b0;
        for (int i = 0; i < 4; i++) send_hash(32'hB000_0000 + 32'(i));
        tick();
        d0 = qsel_drop_cnt;
        send_hash(32'hB000_0004);
        qif.ready = 1'b1;
        tick();
        qif.ready = 1'b0;
        tick();
        chk("t5_no_drop", 64'(qsel_drop_cnt), 64'(d0));
        chk("t5_still_full", 64'(m_cnt), 64'(DEPTH));
        chk("t5_head", 64'(qif.hash), 64'hB000_0001);
        drain("t5");

        // mid-operation reset
        qif.ready = 1'b0;
        for (int i = 0; i < 3; i++) send_hash(32'hC000_0000 + 32'(i));
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_valid_async", 64'(qif.valid), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        cfg_rss_en = 1'b1;
        send_hash(32'h0000_0005);
        tick();
        chk("t6_tbl_cleared", 64'(qif.queue), 64'h00);
        chk("t6_drop_cleared", 64'(qsel_drop_cnt), 64'd0);
        drain("t6");

        // randomized traffic
        for (int seg = 0; seg < 5; seg++) begin
            int rdy_pct;
            rdy_pct = (seg == 0) ? 20 : (seg == 1) ? 90 : int'($urandom_range(30, 70));
            for (int c = 0; c < 300; c++) begin
                crx_hash_valid = ($urandom_range(0, 9) < 6);
                crx_hash = ($urandom() & 32'hFFFF_FF80) | 32'($urandom_range(0, 15));
                qif.ready = ($urandom_range(0, 99) < rdy_pct);
                cfg_tbl_wr_en = ($urandom_range(0, 4) == 0);
                cfg_tbl_wr_addr = 7'($urandom_range(0, 15));
                cfg_tbl_wr_data = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 15) == 0) cfg_rss_en = ~cfg_rss_en;
                if ($urandom_range(0, 15) == 0) cfg_default_queue = 8'($urandom_range(0, 255));
                tick();
            end
            crx_hash_valid = 1'b0;
            cfg_tbl_wr_en = 1'b0;
        end
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
